clk_period_monitor: RTL and testbench

- Receive-side checker for slow clocks generated in the design, such as clk_1point5hz looped back through an input pin.
- Measures the period of a slow input signal in cycles of the 300 MHz system clock and reports each measurement.
- Flags whether the measured period is within tolerance of an expected value, and flags a stopped input.
- Sits in the top level next to the clock divider; outputs feed LEDs/status pins and simulation checks.

---
 rtl/clk_period_monitor.sv | 238 +++++++++++++++++++++++
 tb/tb_clk_period_monitor.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/clk_period_monitor.sv
// clk_period_monitor
//   Measures the period of a slow, asynchronous input (e.g. a divided clock
//   looped back through a pin) in cycles of the 300 MHz system clock.
//   Each measured period is reported together with a tolerance check.
//   A lock indication asserts after LOCK_COUNT consecutive good periods.
//   A sticky timeout flag asserts if the input stops toggling.
//
//   Optional feature macro: CLK_MON_MINMAX_EN
//     When defined, adds period_min / period_max outputs and a minmax_clear
//     input that track the extremes of the reported periods.
//
//   Handshake: period_valid is a single-cycle strobe with no back-pressure.
//   period / in_range are valid whenever period_valid is high and hold their
//   value until the next strobe. locked and timeout are level outputs.
//
//   SYNC_STAGES must be >= 2. TIMEOUT must be < 2**CNT_W so the counter can
//   never wrap before the timeout fires.

module clk_period_monitor #(
    parameter int CNT_W       = 30,
    parameter int EXP_PERIOD  = 200000000,
    parameter int TOL         = 1000000,
    parameter int TIMEOUT     = 400000000,
    parameter int LOCK_COUNT  = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_300,
    input  logic             reset,
    input  logic             mon_in,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             in_range,
    output logic             locked,
    output logic             timeout
`ifdef CLK_MON_MINMAX_EN
    ,
    output logic [CNT_W-1:0] period_min,
    output logic [CNT_W-1:0] period_max,
    input  logic             minmax_clear
`endif
);

    // ------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------
    localparam int LOCK_W = (LOCK_COUNT < 1) ? 1 : $clog2(LOCK_COUNT + 1);

    // Range bounds are one bit wider than the counter so EXP_PERIOD+TOL
    // cannot overflow for periods close to the counter limit.
    localparam logic [CNT_W:0]    RANGE_LO    = (CNT_W + 1)'(EXP_PERIOD - TOL);
    localparam logic [CNT_W:0]    RANGE_HI    = (CNT_W + 1)'(EXP_PERIOD + TOL);
    localparam logic [CNT_W-1:0]  TIMEOUT_CNT = CNT_W'(TIMEOUT);
    localparam logic [LOCK_W-1:0] LOCK_MAX    = LOCK_W'(LOCK_COUNT);
    localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1);
    localparam logic [LOCK_W-1:0] LOCK_ONE    = LOCK_W'(1);

    // ------------------------------------------------------------------
    // Measurement FSM states
    //   S_IDLE    : waiting for the first rising edge, counter held at 0
    //   S_MEASURE : counting cycles between consecutive rising edges
    // ------------------------------------------------------------------
    typedef enum logic {
        S_IDLE    = 1'b0,
        S_MEASURE = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    // ------------------------------------------------------------------
    // Synchroniser and rising-edge detector
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   synced;
    logic                   rise_det;

    assign synced   = sync_q[SYNC_STAGES-1];
    // prev_q clears to 0 on reset, so an input that is already high is seen
    // as a rising edge once it has passed through the synchroniser.
    assign rise_det = synced & ~prev_q;

    // Shift mon_in through the synchroniser chain and keep the previous
    // synchronised value for edge detection.
    always_ff @(posedge clk_300) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], mon_in};
            prev_q <= synced;
        end
    end

    // ------------------------------------------------------------------
    // Measurement datapath registers
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]  cnt_q,      cnt_d;
    logic [CNT_W-1:0]  period_q,   period_d;
    logic              valid_q,    valid_d;
    logic              in_range_q, in_range_d;
    logic [LOCK_W-1:0] lock_q,     lock_d;
    logic              timeout_q,  timeout_d;
    logic              cnt_in_range;

    // Tolerance window test applied to the running count at the edge.
    assign cnt_in_range = ({1'b0, cnt_q} >= RANGE_LO) &&
                          ({1'b0, cnt_q} <= RANGE_HI);

    // Next-state logic: counting, period capture, lock tracking, timeout.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        period_d   = period_q;
        valid_d    = 1'b0;
        in_range_d = in_range_q;
        lock_d     = lock_q;
        timeout_d  = timeout_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                // The first edge only starts a measurement; nothing is
                // reported because there is no previous edge to measure from.
                if (rise_det) begin
                    cnt_d   = CNT_ONE;
                    state_d = S_MEASURE;
                end
            end

            S_MEASURE: begin
                if (rise_det) begin
                    // An edge on the same cycle as cnt == TIMEOUT wins, so
                    // this branch is checked first.
                    period_d   = cnt_q;
                    valid_d    = 1'b1;
                    in_range_d = cnt_in_range;
                    if (cnt_in_range) begin
                        lock_d = (lock_q == LOCK_MAX) ? lock_q : (lock_q + LOCK_ONE);
                    end else begin
                        lock_d = '0;
                    end
                    cnt_d = CNT_ONE;
                end else if (cnt_q == TIMEOUT_CNT) begin
                    // Input stopped: flag it (sticky), drop lock, and wait
                    // for the input to restart. period/in_range hold.
                    timeout_d = 1'b1;
                    lock_d    = '0;
                    cnt_d     = '0;
                    state_d   = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and datapath registers with synchronous active-high reset.
    always_ff @(posedge clk_300) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            period_q   <= '0;
            valid_q    <= 1'b0;
            in_range_q <= 1'b0;
            lock_q     <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            period_q   <= period_d;
            valid_q    <= valid_d;
            in_range_q <= in_range_d;
            lock_q     <= lock_d;
            timeout_q  <= timeout_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign period       = period_q;
    assign period_valid = valid_q;
    assign in_range     = in_range_q;
    assign timeout      = timeout_q;
    // lock_q is updated on the same edge as period_q, so locked falls in
    // the very cycle period_valid reports an out-of-range period.
    assign locked       = (lock_q == LOCK_MAX) && !timeout_q;

`ifdef CLK_MON_MINMAX_EN
    // ------------------------------------------------------------------
    // Min/max period tracking
    //   Cleared state is min = all ones, max = 0, so the first reported
    //   period after reset/clear naturally loads both through the compare.
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] min_q, min_d;
    logic [CNT_W-1:0] max_q, max_d;

    // Track extremes on each new period; a coincident clear loads both
    // from the new period instead of discarding it.
    always_comb begin
        min_d = min_q;
        max_d = max_q;
        if (valid_d) begin
            if (minmax_clear) begin
                min_d = period_d;
                max_d = period_d;
            end else begin
                if (period_d < min_q) min_d = period_d;
                if (period_d > max_q) max_d = period_d;
            end
        end else if (minmax_clear) begin
            min_d = '1;
            max_d = '0;
        end
    end

    // Min/max registers; reset to the cleared state.
    always_ff @(posedge clk_300) begin
        if (reset) begin
            min_q <= '1;
            max_q <= '0;
        end else begin
            min_q <= min_d;
            max_q <= max_d;
        end
    end

    assign period_min = min_q;
    assign period_max = max_q;
`endif

endmodule

// File: tb/tb_clk_period_monitor.sv
// Testbench for clk_period_monitor (small parameters: EXP_PERIOD=20, TOL=2,
// TIMEOUT=60, LOCK_COUNT=3, CNT_W=8). Stimulus drives rising edges of
// mon_in spaced by hand-chosen periods; each completed period pushes its
// hand-computed {period, in_range, locked, timeout} into exp_q, and a
// separate monitor pops and compares on every period_valid strobe.

module tb_clk_period_monitor;

    localparam int CNT_W = 8;
    localparam int EW    = CNT_W + 3;

    logic             clk_300;
    logic             reset;
    logic             mon_in;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic             in_range;
    logic             locked;
    logic             timeout;
`ifdef CLK_MON_MINMAX_EN
    logic [CNT_W-1:0] period_min;
    logic [CNT_W-1:0] period_max;
    logic             minmax_clear;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] pend;
    bit            pend_valid = 1'b0;

    clk_period_monitor #(
        .CNT_W      (CNT_W),
        .EXP_PERIOD (20),
        .TOL        (2),
        .TIMEOUT    (60),
        .LOCK_COUNT (3),
        .SYNC_STAGES(2)
    ) dut (
        .clk_300     (clk_300),
        .reset       (reset),
        .mon_in      (mon_in),
        .period      (period),
        .period_valid(period_valid),
        .in_range    (in_range),
        .locked      (locked),
        .timeout     (timeout)
`ifdef CLK_MON_MINMAX_EN
        ,
        .period_min  (period_min),
        .period_max  (period_max),
        .minmax_clear(minmax_clear)
`endif
    );

    // ---------------- clock / reset block ----------------
    initial clk_300 = 1'b0;
    always #5 clk_300 = ~clk_300;

    always @(posedge clk_300) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_period"},       32'(period),       32'd0);
        check({tag, "_period_valid"}, 32'(period_valid), 32'd0);
        check({tag, "_in_range"},     32'(in_range),     32'd0);
        check({tag, "_locked"},       32'(locked),       32'd0);
        check({tag, "_timeout"},      32'(timeout),      32'd0);
    endtask

    // ---------------- driver tasks (called at a negedge) ----------------
    // Rising edge on mon_in; completes the pending period, if any.
    task automatic rise_edge();
        if (pend_valid) exp_q.push_back(pend);
        pend_valid = 1'b0;
        mon_in = 1'b1;
    endtask

    // One full period of 'per' cycles with hand-computed expectations.
    task automatic drive_period(input int per, input bit ir, input bit lk, input bit to);
        int hi;
        rise_edge();
        pend       = {CNT_W'(per), ir, lk, to};
        pend_valid = 1'b1;
        hi = per / 2;
        repeat (hi) @(negedge clk_300);
        mon_in = 1'b0;
        repeat (per - hi) @(negedge clk_300);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk_300) begin
        logic [EW-1:0] e;
        if (period_valid) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_valid: got period %0d, expected no strobe (cycle %0d)", period, cyc);
            end else begin
                e = exp_q.pop_front();
                check("valid_period",   32'(period),   32'(e[EW-1:3]));
                check("valid_in_range", 32'(in_range), 32'(e[2]));
                check("valid_locked",   32'(locked),   32'(e[1]));
                check("valid_timeout",  32'(timeout),  32'(e[0]));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int k;
        int waited;
        mon_in = 1'b0;
        reset  = 1'b1;
`ifdef CLK_MON_MINMAX_EN
        minmax_clear = 1'b0;
`endif
        repeat (3) @(negedge clk_300);
        reset = 1'b0;
        check_all_zero("reset");
`ifdef CLK_MON_MINMAX_EN
        check("reset_min", 32'(period_min), 32'd255);
        check("reset_max", 32'(period_max), 32'd0);
`endif

        // Square wave at 20, lock, one 25, relock, boundary periods, relock.
        drive_period(20, 1, 0, 0);
        drive_period(20, 1, 0, 0);
        drive_period(20, 1, 1, 0);
        drive_period(20, 1, 1, 0);
        drive_period(20, 1, 1, 0);
        drive_period(25, 0, 0, 0);
        drive_period(20, 1, 0, 0);
        drive_period(20, 1, 0, 0);
        drive_period(20, 1, 1, 0);
        drive_period(18, 1, 1, 0);
        drive_period(22, 1, 1, 0);
        drive_period(17, 0, 0, 0);
        drive_period(23, 0, 0, 0);
        drive_period(20, 1, 0, 0);
        drive_period(20, 1, 0, 0);
        drive_period(20, 1, 1, 0);

        // Last edge, then hold low: timeout 60 cycles after detection.
        rise_edge();
        k = cyc;
        repeat (10) @(negedge clk_300);
        mon_in = 1'b0;
        while (cyc < k + 62) @(negedge clk_300);
        check("pre_timeout_flag",   32'(timeout), 32'd0);
        check("pre_timeout_locked", 32'(locked),  32'd1);
        @(negedge clk_300);
        check("timeout_flag",   32'(timeout), 32'd1);
        check("timeout_locked", 32'(locked),  32'd0);
        check("timeout_period", 32'(period),  32'd20);
        repeat (20) @(negedge clk_300);

        // Resume: first edge restarts from idle, timeout stays sticky.
        drive_period(20, 1, 0, 1);
        drive_period(20, 1, 0, 1);
        drive_period(20, 1, 0, 1);

        // Reset 10 cycles after an edge discards the partial measurement.
        rise_edge();
        repeat (5) @(negedge clk_300);
        mon_in = 1'b0;
        repeat (5) @(negedge clk_300);
        reset = 1'b1;
        @(negedge clk_300);
        reset = 1'b0;
        pend_valid = 1'b0;
        check_all_zero("midreset");

        drive_period(20, 1, 0, 0);
`ifdef CLK_MON_MINMAX_EN
        drive_period(19, 1, 0, 0);
        drive_period(22, 1, 1, 0);
        rise_edge();
        k = cyc;
        pend       = {CNT_W'(21), 1'b1, 1'b1, 1'b0};
        pend_valid = 1'b1;
        repeat (10) @(negedge clk_300);
        mon_in = 1'b0;
        check("minmax_min", 32'(period_min), 32'd19);
        check("minmax_max", 32'(period_max), 32'd22);
        minmax_clear = 1'b1;
        @(negedge clk_300);
        minmax_clear = 1'b0;
        check("cleared_min", 32'(period_min), 32'd255);
        check("cleared_max", 32'(period_max), 32'd0);
        repeat (3) @(negedge clk_300);
        check("cleared_min_hold", 32'(period_min), 32'd255);
        check("cleared_max_hold", 32'(period_max), 32'd0);
        while (cyc < k + 21) @(negedge clk_300);
        rise_edge();
        repeat (10) @(negedge clk_300);
        mon_in = 1'b0;
        check("reload_min", 32'(period_min), 32'd21);
        check("reload_max", 32'(period_max), 32'd21);
`else
        rise_edge();
        repeat (10) @(negedge clk_300);
        mon_in = 1'b0;
`endif

        // Drain the scoreboard with a bounded wait.
        waited = 0;
        while (exp_q.size() != 0 && waited < 40) begin
            @(negedge clk_300);
            waited++;
        end
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
